// File: rtl/lab82_checker_if.sv
// lab82_checker_if: observation and result signals between the lab
// stimulus side (master) and the response checker (slave).
interface lab82_checker_if;
  localparam int unsigned SMP_W = 16;
  localparam int unsigned ERR_W = 8;

  logic             start;
  logic             d_obs;
  logic             clr_obs;
  logic             q_obs;
  logic             busy;
  logic             done;
  logic             pass;
  logic             err;
  logic [ERR_W-1:0] errcnt;
  logic [SMP_W-1:0] samples;
  logic [SMP_W-1:0] first_err;

  // stimulus / observation side
  modport master (
    output start, d_obs, clr_obs, q_obs,
    input  busy, done, pass, err, errcnt, samples, first_err
  );

  // checker side
  modport slave (
    input  start, d_obs, clr_obs, q_obs,
    output busy, done, pass, err, errcnt, samples, first_err
  );
endinterface

// File: rtl/lab82_checker.sv
// lab82_checker: cycle-accurate response monitor for the async-clear DFF lab
// block. Compares observed Q against an ideal DFF reference for N_SAMPLES
// cycles per run and reports pass/fail with a saturating mismatch count.
// Optional feature: define LAB82_CHECKER_FIRSTERR_EN to capture the 0-based
// index of the first mismatch in first_err (otherwise it reads 16'hFFFF).
module lab82_checker #(
  parameter int unsigned N_SAMPLES = 64
) (
  input  logic           clk,
  input  logic           rst,
  lab82_checker_if.slave bus
);
  localparam int unsigned SMP_W = 16;
  localparam int unsigned ERR_W = 8;
  localparam logic [SMP_W-1:0] LAST_IDX = SMP_W'(N_SAMPLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [SMP_W-1:0] NO_FIRST = {SMP_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             busy_q;
  logic             busy_d;
  logic             done_q;
  logic             done_d;
  logic             pass_q;
  logic             pass_d;
  logic             err_q;
  logic             exp_q;
  logic [ERR_W-1:0] errcnt_q;
  logic [ERR_W-1:0] errcnt_d;
  logic [SMP_W-1:0] samples_q;
  logic             run_start_c;
  logic             compare_c;
  logic             last_c;
  logic             exp_now_c;
  logic             mismatch_c;

  // run-control decodes and the compare against the reference bit
  always_comb begin
    run_start_c = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;
    compare_c   = (state_q == S_RUN);
    last_c      = compare_c && (samples_q == LAST_IDX);
    exp_now_c   = bus.clr_obs ? 1'b0 : exp_q;
    mismatch_c  = compare_c && (bus.q_obs !== exp_now_c);
  end

  // next mismatch count: cleared on run start, saturates at all-ones
  always_comb begin
    errcnt_d = errcnt_q;
    if (run_start_c) begin
      errcnt_d = '0;
    end else if (mismatch_c && (errcnt_q != ERR_MAX)) begin
      errcnt_d = errcnt_q + ERR_W'(1);
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_ARM;
      S_ARM:   state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_DONE;
      S_DONE:  if (bus.start) state_d = S_ARM;
      default: state_d = S_IDLE;
    endcase
  end

  // status outputs for the state being entered, registered below
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    pass_d = 1'b0;
    if ((state_d == S_ARM) || (state_d == S_RUN)) begin
      busy_d = 1'b1;
    end
    if (state_d == S_DONE) begin
      done_d = 1'b1;
      pass_d = (errcnt_d == '0);
    end
  end

  // status output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  // reference bit, sample counter, sticky error and mismatch count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q     <= 1'b0;
      errcnt_q  <= '0;
      samples_q <= '0;
      err_q     <= 1'b0;
    end else begin
      errcnt_q <= errcnt_d;
      if (run_start_c) begin
        samples_q <= '0;
        err_q     <= 1'b0;
      end else if (compare_c) begin
        samples_q <= samples_q + SMP_W'(1);
        if (mismatch_c) begin
          err_q <= 1'b1;
        end
      end
      if ((state_q == S_ARM) || compare_c) begin
        exp_q <= bus.clr_obs ? 1'b0 : bus.d_obs;
      end
    end
  end

`ifdef LAB82_CHECKER_FIRSTERR_EN
  logic [SMP_W-1:0] first_err_q;

  // latch the pre-increment sample index of the first mismatch in a run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_q <= NO_FIRST;
    end else if (run_start_c) begin
      first_err_q <= NO_FIRST;
    end else if (mismatch_c && !err_q) begin
      first_err_q <= samples_q;
    end
  end

  assign bus.first_err = first_err_q;
`else
  assign bus.first_err = NO_FIRST;
`endif

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err     = err_q;
  assign bus.errcnt  = errcnt_q;
  assign bus.samples = samples_q;
endmodule

// File: tb/tb_lab82_checker.sv
// tb_lab82_checker: drives three checkers (N_SAMPLES = 8, 300, 1) from one
// shared observation stream produced by an ideal async-clear DFF with an
// optional fault (Q inversion). Expected results come from a recorded
// per-edge history evaluated against the ideal DFF definition.
module tb_lab82_checker;
  localparam int HMAX = 4096;
`ifdef LAB82_CHECKER_FIRSTERR_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif
  // {busy, done, pass, err, errcnt[8], samples[16], first_err[16]}
  localparam logic [43:0] RST_VEC = {4'b0000, 8'h00, 16'h0000, 16'hFFFF};

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic d     = 1'b0;
  logic clr   = 1'b0;
  logic flip  = 1'b0;
  logic q_ff  = 1'b0;
  logic q_obs;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  logic hd [HMAX];
  logic hc [HMAX];
  logic hq [HMAX];

  always #5 clk = ~clk;

  // ideal DFF under test, with async clear and optional output inversion
  always @(posedge clk) q_ff <= clr ? 1'b0 : d;
  assign q_obs = (clr ? 1'b0 : q_ff) ^ flip;

  // history of what every checker saw at each rising edge
  always @(posedge clk) begin
    if (cyc < HMAX) begin
      hd[cyc] <= d;
      hc[cyc] <= clr;
      hq[cyc] <= q_obs;
    end
    cyc <= cyc + 1;
  end

  lab82_checker_if if8 ();
  lab82_checker_if if300 ();
  lab82_checker_if if1 ();

  assign if8.start     = start;
  assign if8.d_obs     = d;
  assign if8.clr_obs   = clr;
  assign if8.q_obs     = q_obs;
  assign if300.start   = start;
  assign if300.d_obs   = d;
  assign if300.clr_obs = clr;
  assign if300.q_obs   = q_obs;
  assign if1.start     = start;
  assign if1.d_obs     = d;
  assign if1.clr_obs   = clr;
  assign if1.q_obs     = q_obs;

  lab82_checker #(.N_SAMPLES(8))   dut8   (.clk(clk), .rst(rst), .bus(if8.slave));
  lab82_checker #(.N_SAMPLES(300)) dut300 (.clk(clk), .rst(rst), .bus(if300.slave));
  lab82_checker #(.N_SAMPLES(1))   dut1   (.clk(clk), .rst(rst), .bus(if1.slave));

  wire [43:0] obs8   = {if8.busy, if8.done, if8.pass, if8.err, if8.errcnt,
                        if8.samples, if8.first_err};
  wire [43:0] obs300 = {if300.busy, if300.done, if300.pass, if300.err, if300.errcnt,
                        if300.samples, if300.first_err};
  wire [43:0] obs1   = {if1.busy, if1.done, if1.pass, if1.err, if1.errcnt,
                        if1.samples, if1.first_err};

  // mismatches among the first j compares of a run started at edge k;
  // compare i happens at edge k+2+i and expects the ideal DFF output there
  function automatic void model(input int k, input int j, output int ecnt, output int first);
    int   t;
    logic want;
    ecnt  = 0;
    first = -1;
    for (int i = 0; i < j; i++) begin
      t = k + 2 + i;
      if (t < HMAX) begin
        want = hc[t] ? 1'b0 : (hc[t-1] ? 1'b0 : hd[t-1]);
        if (hq[t] !== want) begin
          if (first < 0) first = i;
          if (ecnt < 255) ecnt++;
        end
      end
    end
  endfunction

  // expected output vector after j of n compares of a run started at edge k
  function automatic logic [43:0] want_vec(input int k, input int n, input int j);
    int          ecnt;
    int          first;
    logic        dn;
    logic [15:0] fe;
    model(k, j, ecnt, first);
    dn = (j >= n);
    fe = (FE_EN && (first >= 0)) ? 16'(first) : 16'hFFFF;
    return {~dn, dn, dn && (ecnt == 0), ecnt != 0, 8'(ecnt), 16'(j), fe};
  endfunction

  // compares completed after drive m of a run (m = 0 is the start edge)
  function automatic int jn(input int m, input int n);
    int j;
    j = (m > 0) ? m - 1 : 0;
    return (j > n) ? n : j;
  endfunction

  // apply one cycle of stimulus across the next rising edge
  task automatic cyc_drive(input logic s, input logic dd, input logic cc, input logic ff);
    start = s;
    d     = dd;
    clr   = cc;
    flip  = ff;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (obs8 !== RST_VEC) begin fails++; $display("FAIL reset_n8 got %h want %h", obs8, RST_VEC); end
    checks++;
    if (obs300 !== RST_VEC) begin fails++; $display("FAIL reset_n300 got %h want %h", obs300, RST_VEC); end
    checks++;
    if (obs1 !== RST_VEC) begin fails++; $display("FAIL reset_n1 got %h want %h", obs1, RST_VEC); end
    checks++;
    rst = 1'b0;
    cyc_drive(1'b0, 1'b1, 1'b0, 1'b0);
    cyc_drive(1'b0, 1'b0, 1'b0, 1'b0);
    if (obs8 !== RST_VEC) begin fails++; $display("FAIL idle_hold got %h want %h", obs8, RST_VEC); end
    checks++;
  endtask

  task automatic test_clean_run();
    int          k;
    logic        dv;
    logic [43:0] w;
    dv = 1'($urandom);
    k  = cyc;
    for (int m = 0; m <= 10; m++) begin
      cyc_drive(m == 0, dv, 1'b0, 1'b0);
      dv = ~dv;
      w = want_vec(k, 8, jn(m, 8));
      if (obs8 !== w) begin fails++; $display("FAIL clean_n8 m=%0d got %h want %h", m, obs8, w); end
      checks++;
      w = want_vec(k, 1, jn(m, 1));
      if (obs1 !== w) begin fails++; $display("FAIL clean_n1 m=%0d got %h want %h", m, obs1, w); end
      checks++;
    end
    if (obs8 !== {4'b0110, 8'h00, 16'd8, 16'hFFFF}) begin
      fails++; $display("FAIL clean_final got %h want %h", obs8, {4'b0110, 8'h00, 16'd8, 16'hFFFF});
    end
    checks++;
    if (obs1 !== {4'b0110, 8'h00, 16'd1, 16'hFFFF}) begin
      fails++; $display("FAIL n1_final got %h want %h", obs1, {4'b0110, 8'h00, 16'd1, 16'hFFFF});
    end
    checks++;
  endtask

  task automatic test_clear_window();
    int          k;
    logic        dv;
    logic [43:0] w;
    logic [43:0] fin;
    for (int r = 0; r < 2; r++) begin
      dv = 1'($urandom);
      k  = cyc;
      for (int m = 0; m <= 9; m++) begin
        cyc_drive(m == 0, dv, (m == 5) || (m == 6), (r == 1) && (m == 5));
        dv = ~dv;
        w = want_vec(k, 8, jn(m, 8));
        if (obs8 !== w) begin fails++; $display("FAIL clrwin r=%0d m=%0d got %h want %h", r, m, obs8, w); end
        checks++;
      end
      fin = (r == 0) ? {4'b0110, 8'h00, 16'd8, 16'hFFFF}
                     : {4'b0101, 8'h01, 16'd8, (FE_EN ? 16'd3 : 16'hFFFF)};
      if (obs8 !== fin) begin fails++; $display("FAIL clrwin_final r=%0d got %h want %h", r, obs8, fin); end
      checks++;
    end
  endtask

  task automatic test_start_ignored();
    int          k;
    logic [43:0] w;
    k = cyc;
    for (int m = 0; m <= 9; m++) begin
      cyc_drive((m == 0) || ((m >= 1) && ($urandom % 2 == 0)), 1'($urandom), 1'b0,
                ($urandom % 3) == 0);
      w = want_vec(k, 8, jn(m, 8));
      if (obs8 !== w) begin fails++; $display("FAIL startign m=%0d got %h want %h", m, obs8, w); end
      checks++;
    end
    k = cyc;
    for (int m = 0; m <= 9; m++) begin
      cyc_drive(m == 0, 1'($urandom), 1'b0, 1'b0);
      w = want_vec(k, 8, jn(m, 8));
      if (obs8 !== w) begin fails++; $display("FAIL restart m=%0d got %h want %h", m, obs8, w); end
      checks++;
    end
    if (obs8 !== {4'b0110, 8'h00, 16'd8, 16'hFFFF}) begin
      fails++; $display("FAIL restart_final got %h want %h", obs8, {4'b0110, 8'h00, 16'd8, 16'hFFFF});
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int          k1;
    int          kc;
    int          ndone;
    logic [43:0] w;
    k1    = cyc;
    ndone = 0;
    for (int m = 0; m < 30; m++) begin
      cyc_drive(1'b1, 1'($urandom), ($urandom % 6) == 0, ($urandom % 5) == 0);
      kc = k1 + 10 * (m / 10);
      w  = want_vec(kc, 8, jn(m % 10, 8));
      if (obs8 !== w) begin fails++; $display("FAIL b2b m=%0d got %h want %h", m, obs8, w); end
      checks++;
      if (if8.done) ndone++;
    end
    start = 1'b0;
    if (ndone !== 3) begin fails++; $display("FAIL b2b_done_cycles got %0d want 3", ndone); end
    checks++;
  endtask

  task automatic test_random();
    int          k;
    logic [43:0] w;
    for (int r = 0; r < 4; r++) begin
      k = cyc;
      for (int m = 0; m <= 9; m++) begin
        cyc_drive(m == 0, 1'($urandom), ($urandom % 5) == 0, ($urandom % 4) == 0);
        w = want_vec(k, 8, jn(m, 8));
        if (obs8 !== w) begin fails++; $display("FAIL random r=%0d m=%0d got %h want %h", r, m, obs8, w); end
        checks++;
      end
    end
  endtask

  task automatic test_clr_abort();
    int          k;
    logic        dv;
    logic [43:0] w;
    dv = 1'b0;
    k  = cyc;
    for (int m = 0; m <= 5; m++) begin
      cyc_drive(m == 0, dv, 1'b0, m == 3);
      dv = ~dv;
      w = want_vec(k, 8, jn(m, 8));
      if (obs8 !== w) begin fails++; $display("FAIL abort_pre m=%0d got %h want %h", m, obs8, w); end
      checks++;
    end
    #1 rst = 1'b1;
    #1;
    if (obs8 !== RST_VEC) begin fails++; $display("FAIL abort_n8 got %h want %h", obs8, RST_VEC); end
    checks++;
    if (obs300 !== RST_VEC) begin fails++; $display("FAIL abort_n300 got %h want %h", obs300, RST_VEC); end
    checks++;
    if (obs1 !== RST_VEC) begin fails++; $display("FAIL abort_n1 got %h want %h", obs1, RST_VEC); end
    checks++;
    #1 rst = 1'b0;
    cyc_drive(1'b0, dv, 1'b0, 1'b0);
    if (obs8 !== RST_VEC) begin fails++; $display("FAIL abort_idle got %h want %h", obs8, RST_VEC); end
    checks++;
    k = cyc;
    for (int m = 0; m <= 9; m++) begin
      cyc_drive(m == 0, dv, 1'b0, 1'b0);
      dv = ~dv;
      w = want_vec(k, 8, jn(m, 8));
      if (obs8 !== w) begin fails++; $display("FAIL abort_rerun m=%0d got %h want %h", m, obs8, w); end
      checks++;
    end
    if (obs8 !== {4'b0110, 8'h00, 16'd8, 16'hFFFF}) begin
      fails++; $display("FAIL abort_final got %h want %h", obs8, {4'b0110, 8'h00, 16'd8, 16'hFFFF});
    end
    checks++;
  endtask

  task automatic test_saturate();
    int          k;
    logic [43:0] w;
    logic [43:0] fin;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    k = cyc;
    for (int m = 0; m <= 302; m++) begin
      cyc_drive(m == 0, 1'($urandom), ($urandom % 8) == 0, 1'b1);
      w = want_vec(k, 300, jn(m, 300));
      if (obs300 !== w) begin fails++; $display("FAIL saturate m=%0d got %h want %h", m, obs300, w); end
      checks++;
    end
    fin = {4'b0101, 8'hFF, 16'd300, (FE_EN ? 16'd0 : 16'hFFFF)};
    if (obs300 !== fin) begin fails++; $display("FAIL saturate_final got %h want %h", obs300, fin); end
    checks++;
  endtask

  // run-away guard
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_run();
    test_clear_window();
    test_start_ignored();
    test_back_to_back();
    test_random();
    test_clr_abort();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/lab82_checker.md
# lab82_checker

Self-checking response monitor for the async-clear D flip-flop lab block: it sits opposite the stimulus side and observes the DUT's applied D, applied clear and produced Q on the shared clock. It runs a cycle-accurate reference model and compares Q every cycle for a programmed number of samples. It then reports pass/fail with a saturating mismatch count. It is used in hardware on the lab board and in simulation as a drop-in checker.

## Interface

Parameters:
- N_SAMPLES, 64, number of compared cycles per run (legal 1..65535)

Ports:
- C  input  1  clock; all sampling on rising edge
- CLR  input  1  checker reset, asynchronous, active-high
- START  input  1  run request, sampled in IDLE and DONE only
- D_OBS  input  1  D as applied to the DUT
- CLR_OBS  input  1  clear as applied to the DUT; must change only synchronously to C and be held ≥1 cycle
- Q_OBS  input  1  DUT output Q
- BUSY  output  1  high in ARM and RUN
- DONE  output  1  high in DONE
- PASS  output  1  high in DONE when ERRCNT == 0
- ERR  output  1  sticky, high from first mismatch until next run start or CLR
- ERRCNT  output  8  mismatch count, saturates at 255
- SAMPLES  output  16  number of compares done in current/last run
- FIRST_ERR  output  16  SAMPLES value of first mismatch (see Configuration)

## Operation

- Reset (CLR=1, immediate): state IDLE; BUSY=DONE=PASS=ERR=0; ERRCNT=0; SAMPLES=0; exp=0; FIRST_ERR=16'hFFFF.
- Reference model: internal bit exp. Expected Q at an edge = CLR_OBS ? 0 : exp. After the compare, exp <= CLR_OBS ? 0 : D_OBS.
- States:
  - IDLE: START=1 -> ARM. Clears ERRCNT, SAMPLES, ERR, FIRST_ERR=FFFF on that edge.
  - ARM: one cycle, no compare; loads exp from D_OBS/CLR_OBS; -> RUN.
  - RUN: each edge compares Q_OBS with expected. Mismatch -> ERRCNT+1 (hold at 255), ERR=1. SAMPLES+1 every edge. The edge performing compare number N_SAMPLES -> DONE. START ignored.
  - DONE: outputs frozen; START=1 -> ARM with same clearing as from IDLE.
- PASS = DONE && ERRCNT==0; combinational from registered state.
- CLR mid-run: aborts immediately to reset values; no partial result retained.
- Q_OBS X/Z in simulation counts as mismatch (compare with !==).

## Timing

- START high at edge k (IDLE/DONE) -> BUSY high after k; ARM at k+1; first compare at edge k+2.
- Last compare at edge k+1+N_SAMPLES; DONE/PASS high right after that edge, BUSY low, ERRCNT/SAMPLES final (SAMPLES == N_SAMPLES).
- Compare result visible in ERRCNT/ERR one edge after the Q_OBS value it judged, i.e. registered on the comparing edge.
- N_SAMPLES=1: ARM then exactly one compare then DONE.
- START held high continuously: run restarts at every DONE edge after the one where DONE entered (DONE visible for exactly one cycle).

## Configuration

- LAB82_CHECKER_FIRSTERR_EN defined: on the first mismatch of a run FIRST_ERR captures the pre-increment SAMPLES value (0-based index); held until next run start or CLR; stays FFFF if no mismatch.
- Not defined: capture logic omitted; FIRST_ERR constantly 16'hFFFF; all other behaviour identical.

## Test plan

- N_SAMPLES=8, ideal DFF model drives Q_OBS, D_OBS toggling every cycle, CLR_OBS=0, START pulse -> DONE after 10 edges, PASS=1, ERRCNT=0, SAMPLES=8, FIRST_ERR=FFFF.
- Same, CLR_OBS high for cycles 3–4 with DUT Q forced 0 -> PASS=1; with Q_OBS not cleared at cycle 3 -> ERRCNT=1, FIRST_ERR=3 (macro on).
- Q_OBS inverted for all cycles, N_SAMPLES=300 -> ERRCNT=255 (saturated), ERR=1, PASS=0, SAMPLES=300.
- CLR asserted between clock edges in RUN at sample 4 -> all outputs return to reset values immediately; START again gives a clean full run.
- START pulses during RUN -> ignored, SAMPLES still ends at N_SAMPLES; START in DONE -> counters cleared, new run completes.
- Build without LAB82_CHECKER_FIRSTERR_EN, injected mismatch at sample 2 -> ERRCNT=1, FIRST_ERR=FFFF.
